// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM keypad front-end: key codes, FSM states,
// amount width and small decode helpers.
package cajero_pkg;

   localparam int MONTO_W = 32;

   localparam logic [3:0] TECLA_ENTER  = 4'hA;
   localparam logic [3:0] TECLA_BORRAR = 4'hB;

   typedef enum logic [1:0] {
      INACTIVO,
      LIBRE,
      FILTRO,
      SOSTENIDA
   } estado_t;

   // What the top level does with one accepted key.
   typedef enum logic [2:0] {
      ACC_NADA,
      ACC_DIGITO,
      ACC_SUMAR,
      ACC_ENTREGAR,
      ACC_BORRAR,
      ACC_ERROR
   } accion_t;

   function automatic logic es_digito(input logic [3:0] c);
      return c <= 4'd9;
   endfunction

   function automatic logic [MONTO_W-1:0] agregar_digito(input logic [MONTO_W-1:0] acc,
                                                          input logic [3:0]         c);
      return acc * MONTO_W'(10) + MONTO_W'(c);
   endfunction

endpackage

// File: rtl/filtro_rebote.sv
// Key filter: state machine, sample counter and code register; emits a
// one-cycle tecla_valida with the accepted code. TECLADO_REBOTE_EN selects debouncing.
module filtro_rebote
   import cajero_pkg::*;
#(
   parameter int CICLOS_REBOTE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tarjeta,
   input  logic       presionada,
   input  logic [3:0] tecla,
   output logic       tecla_valida,
   output logic [3:0] codigo
);

   if (CICLOS_REBOTE < 1 || CICLOS_REBOTE > 255) begin : g_rebote_invalido
      $error("CICLOS_REBOTE must be within 1..255");
   end

   estado_t    estado, estado_sig;
   logic [3:0] codigo_sig;

`ifdef TECLADO_REBOTE_EN

   localparam logic [7:0] LIMITE = 8'(CICLOS_REBOTE - 1);

   logic [7:0] cuenta, cuenta_sig;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado <= INACTIVO;
         codigo <= '0;
         cuenta <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the values from before this edge, independent of order.
         estado <= estado_sig;
         codigo <= codigo_sig;
         cuenta <= cuenta_sig;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // left one unassigned would infer a latch.
      estado_sig   = estado;
      codigo_sig   = codigo;
      cuenta_sig   = cuenta;
      tecla_valida = 1'b0;
      if (!tarjeta) begin
         estado_sig = INACTIVO;
         codigo_sig = '0;
         cuenta_sig = '0;
      end else begin
         case (estado)
            INACTIVO: estado_sig = LIBRE;
            LIBRE: begin
               if (presionada) begin
                  codigo_sig = tecla;
                  cuenta_sig = '0;
                  estado_sig = FILTRO;
               end
            end
            FILTRO: begin
               if (!presionada) begin
                  estado_sig = LIBRE;
               end else if (tecla != codigo) begin
                  codigo_sig = tecla;
                  cuenta_sig = '0;
               end else if (cuenta == LIMITE) begin
                  tecla_valida = 1'b1;
                  cuenta_sig   = '0;
                  estado_sig   = SOSTENIDA;
               end else begin
                  cuenta_sig = cuenta + 8'd1;
               end
            end
            SOSTENIDA: begin
               // Only a run of release samples ends the press; code changes are ignored.
               if (presionada) begin
                  cuenta_sig = '0;
               end else if (cuenta == LIMITE) begin
                  cuenta_sig = '0;
                  estado_sig = LIBRE;
               end else begin
                  cuenta_sig = cuenta + 8'd1;
               end
            end
            default: estado_sig = INACTIVO;
         endcase
      end
   end

`else

   // Without debouncing the first sampled press is accepted; the flag delays
   // the action by one edge so the strobe lands at k+1.
   logic aceptada, aceptada_sig;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado   <= INACTIVO;
         codigo   <= '0;
         aceptada <= 1'b0;
      end else begin
         estado   <= estado_sig;
         codigo   <= codigo_sig;
         aceptada <= aceptada_sig;
      end
   end

   always_comb begin
      estado_sig   = estado;
      codigo_sig   = codigo;
      aceptada_sig = 1'b0;
      if (!tarjeta) begin
         estado_sig = INACTIVO;
         codigo_sig = '0;
      end else begin
         case (estado)
            INACTIVO: estado_sig = LIBRE;
            LIBRE: begin
               if (presionada) begin
                  codigo_sig   = tecla;
                  aceptada_sig = 1'b1;
                  estado_sig   = SOSTENIDA;
               end
            end
            SOSTENIDA: begin
               if (!presionada) begin
                  estado_sig = LIBRE;
               end
            end
            default: estado_sig = LIBRE;
         endcase
      end
   end

   assign tecla_valida = aceptada;

`endif

endmodule

// File: rtl/interfaz_teclado.sv
// ATM keypad front-end: PIN digits and decimal amount accumulation on top of
// filtro_rebote. Debounce enabled with TECLADO_REBOTE_EN.
module interfaz_teclado
   import cajero_pkg::*;
#(
   parameter int CICLOS_REBOTE = 4,
   parameter int MAX_DIGITOS   = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tarjetaRecibida,
   input  logic               modoMonto,
   input  logic               teclaPresionada,
   input  logic [3:0]         tecla,
   output logic [3:0]         digito,
   output logic               digitoSTB,
   output logic [MONTO_W-1:0] monto,
   output logic               montoSTB,
   output logic               errorTecla
);

   if (MAX_DIGITOS < 1 || MAX_DIGITOS > 9) begin : g_max_digitos_invalido
      $error("MAX_DIGITOS must be within 1..9");
   end

   localparam logic [3:0] CUENTA_MAX = 4'(MAX_DIGITOS);

   logic               tecla_valida;
   logic [3:0]         codigo;
   logic [MONTO_W-1:0] acumulado;
   logic [3:0]         cuenta;
   accion_t            accion;

   filtro_rebote #(
      .CICLOS_REBOTE(CICLOS_REBOTE)
   ) u_filtro (
      .clk         (clk),
      .rst         (rst),
      .tarjeta     (tarjetaRecibida),
      .presionada  (teclaPresionada),
      .tecla       (tecla),
      .tecla_valida(tecla_valida),
      .codigo      (codigo)
   );

   always_comb begin
      accion = ACC_NADA;
      if (tecla_valida) begin
         if (!modoMonto) begin
            accion = ACC_DIGITO;
         end else if (es_digito(codigo)) begin
            accion = (cuenta < CUENTA_MAX) ? ACC_SUMAR : ACC_ERROR;
         end else if (codigo == TECLA_ENTER) begin
            accion = (cuenta != 4'd0) ? ACC_ENTREGAR : ACC_ERROR;
         end else if (codigo == TECLA_BORRAR) begin
            accion = ACC_BORRAR;
         end else begin
            accion = ACC_ERROR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digito     <= '0;
         digitoSTB  <= 1'b0;
         monto      <= '0;
         montoSTB   <= 1'b0;
         errorTecla <= 1'b0;
         acumulado  <= '0;
         cuenta     <= '0;
      end else begin
         digitoSTB  <= 1'b0;
         montoSTB   <= 1'b0;
         errorTecla <= 1'b0;
         if (!tarjetaRecibida) begin
            // Card removal outranks any key accepted in the same cycle.
            digito    <= '0;
            monto     <= '0;
            acumulado <= '0;
            cuenta    <= '0;
         end else if (!modoMonto) begin
            acumulado <= '0;
            cuenta    <= '0;
            if (accion == ACC_DIGITO) begin
               digito    <= codigo;
               digitoSTB <= 1'b1;
            end
         end else begin
            case (accion)
               ACC_SUMAR: begin
                  acumulado <= agregar_digito(acumulado, codigo);
                  cuenta    <= cuenta + 4'd1;
               end
               ACC_ENTREGAR: begin
                  monto     <= acumulado;
                  montoSTB  <= 1'b1;
                  acumulado <= '0;
                  cuenta    <= '0;
               end
               ACC_BORRAR: begin
                  acumulado <= '0;
                  cuenta    <= '0;
               end
               ACC_ERROR: errorTecla <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule
